// File: rtl/mem_seq_pkg.sv
// Shared encodings for the byte-wide memory port sequencer: FSM states,
// requester ownership and access direction.
package mem_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD0  = 3'd1,
      S_RD1  = 3'd2,
      S_RD2  = 3'd3,
      S_WR0  = 3'd4,
      S_WR1  = 3'd5
   } state_t;

   localparam logic OWN_IF   = 1'b0;
   localparam logic OWN_DATA = 1'b1;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/mem_rr_pick.sv
// Two-way requester picker: round-robin against the last grant when FAIR=1,
// fixed data-first priority when FAIR=0.
module mem_rr_pick
   import mem_seq_pkg::*;
#(
   parameter bit FAIR = 1'b1
) (
   input  logic req_if,
   input  logic req_data,
   input  logic last_grant,
   output logic grant_data,
   output logic grant_valid
);

   always_comb begin
      grant_valid = req_if | req_data;
      grant_data  = req_data;
      if (req_if && req_data) begin
         grant_data = FAIR ? (last_grant == OWN_IF) : 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_sequencer.sv
// Arbitrates one byte-wide memory between fetch and MEM stage, splitting each
// 16-bit access into two little-endian byte accesses.
//
// state | meaning
// IDLE  | no access; grant a requester when no done pulse is pending
// RD0   | read strobe on addr (low byte)
// RD1   | read strobe on addr+1; capture low byte
// RD2   | capture high byte; deliver word and pulse owner's done
// WR0   | write low byte to addr
// WR1   | write high byte to addr+1; pulse data_done
module mem_port_sequencer
   import mem_seq_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter bit FAIR   = 1'b1
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [15:0]       if_rdata,
   output logic              if_done,
   output logic              if_stall,
   input  logic              data_req,
   input  logic              data_rw,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [15:0]       data_wdata,
   output logic [15:0]       data_rdata,
   output logic              data_done,
   output logic              data_stall,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              busy
);

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              rw_q, rw_d;
   logic              last_grant_q, last_grant_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] addr_inc;
   logic [15:0]       wdata_q, wdata_d;
   logic [7:0]        lo_q, lo_d;
   logic [15:0]       if_rdata_q, if_rdata_d;
   logic [15:0]       data_rdata_q, data_rdata_d;
   logic              if_done_q, if_done_d;
   logic              data_done_q, data_done_d;
   logic              grant_data, grant_valid;

   assign addr_inc = addr_q + ADDR_W'(1);

   mem_rr_pick #(.FAIR(FAIR)) u_pick (
      .req_if      (if_req),
      .req_data    (data_req),
      .last_grant  (last_grant_q),
      .grant_data  (grant_data),
      .grant_valid (grant_valid)
   );

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      rw_d         = rw_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      lo_d         = lo_q;
      if_rdata_d   = if_rdata_q;
      data_rdata_d = data_rdata_q;
      if_done_d    = 1'b0;
      data_done_d  = 1'b0;
      mem_addr     = '0;
      mem_re       = 1'b0;
      mem_we       = 1'b0;
      mem_wdata    = 8'h00;
      case (state_q)
         S_IDLE: begin
            // A done pulse means the finished requester may still hold req.
            if (!if_done_q && !data_done_q && grant_valid) begin
               owner_d      = grant_data ? OWN_DATA : OWN_IF;
               last_grant_d = grant_data ? OWN_DATA : OWN_IF;
               rw_d         = grant_data ? data_rw : RW_READ;
               addr_d       = grant_data ? data_addr : if_addr;
               wdata_d      = grant_data ? data_wdata : wdata_q;
               state_d      = (rw_d == RW_WRITE) ? S_WR0 : S_RD0;
            end
         end
         S_RD0: begin
            mem_addr = addr_q;
            mem_re   = 1'b1;
            state_d  = S_RD1;
         end
         S_RD1: begin
            mem_addr = addr_inc;
            mem_re   = 1'b1;
            lo_d     = mem_rdata;
            state_d  = S_RD2;
         end
         S_RD2: begin
            if (owner_q == OWN_DATA) begin
               data_rdata_d = {mem_rdata, lo_q};
               data_done_d  = 1'b1;
            end else begin
               if_rdata_d = {mem_rdata, lo_q};
               if_done_d  = 1'b1;
            end
            state_d = S_IDLE;
         end
         S_WR0: begin
            mem_addr  = addr_q;
            mem_we    = 1'b1;
            mem_wdata = wdata_q[7:0];
            state_d   = S_WR1;
         end
         S_WR1: begin
            mem_addr    = addr_inc;
            mem_we      = 1'b1;
            mem_wdata   = wdata_q[15:8];
            data_done_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_IF;
         rw_q         <= RW_READ;
         last_grant_q <= OWN_DATA;
         addr_q       <= '0;
         wdata_q      <= 16'h0000;
         lo_q         <= 8'h00;
         if_rdata_q   <= 16'h0000;
         data_rdata_q <= 16'h0000;
         if_done_q    <= 1'b0;
         data_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         rw_q         <= rw_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         lo_q         <= lo_d;
         if_rdata_q   <= if_rdata_d;
         data_rdata_q <= data_rdata_d;
         if_done_q    <= if_done_d;
         data_done_q  <= data_done_d;
      end
   end

   assign if_rdata   = if_rdata_q;
   assign data_rdata = data_rdata_q;
   assign if_done    = if_done_q;
   assign data_done  = data_done_q;
   assign if_stall   = if_req & ~if_done_q;
   assign data_stall = data_req & ~data_done_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Bench for mem_port_sequencer: directed vectors, contention under both
// arbitration modes, mid-write reset, and randomized traffic against a word model.
module tb_mem_port_sequencer;

   logic        CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   logic        reset;
   logic        if_req, data_req, data_rw;
   logic [15:0] if_addr, data_addr, data_wdata;
   logic [15:0] if_rdata, data_rdata;
   logic        if_done, if_stall, data_done, data_stall;
   logic [15:0] mem_addr;
   logic        mem_re, mem_we, busy;
   logic [7:0]  mem_wdata, mem_rdata;

   logic        f0_if_req, f0_data_req;
   logic [15:0] f0_if_rdata, f0_data_rdata, f0_mem_addr;
   logic        f0_if_done, f0_if_stall, f0_data_done, f0_data_stall;
   logic        f0_mem_re, f0_mem_we, f0_busy;
   logic [7:0]  f0_mem_wdata, f0_mem_rdata;

   mem_port_sequencer #(.ADDR_W(16), .FAIR(1'b1)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_done(if_done), .if_stall(if_stall),
      .data_req(data_req), .data_rw(data_rw), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_rdata(data_rdata),
      .data_done(data_done), .data_stall(data_stall),
      .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_port_sequencer #(.ADDR_W(16), .FAIR(1'b0)) dut_fixed (
      .CLOCK_50(CLOCK_50), .reset(reset),
      .if_req(f0_if_req), .if_addr(if_addr), .if_rdata(f0_if_rdata),
      .if_done(f0_if_done), .if_stall(f0_if_stall),
      .data_req(f0_data_req), .data_rw(data_rw), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_rdata(f0_data_rdata),
      .data_done(f0_data_done), .data_stall(f0_data_stall),
      .mem_addr(f0_mem_addr), .mem_re(f0_mem_re), .mem_we(f0_mem_we),
      .mem_wdata(f0_mem_wdata), .mem_rdata(f0_mem_rdata), .busy(f0_busy)
   );

   // Memory image: seed 0 is the directed preload, otherwise a hash fill.
   function automatic logic [7:0] init_byte(input int seed, input int i);
      logic [31:0] h;
      if (seed == 0) begin
         case (i)
            16'h0010: return 8'h34;
            16'h0011: return 8'h12;
            16'h0012: return 8'h9A;
            16'hFFFF: return 8'hAA;
            16'h0000: return 8'h55;
            default:  return 8'h00;
         endcase
      end
      h = (32'(i) * 32'h9E3779B1) ^ (32'(seed) * 32'h85EBCA77);
      return h[23:16] ^ h[7:0];
   endfunction

   logic [7:0] mem [0:65535];
   logic [7:0] ref_mem [0:65535];
   logic       init_go;
   int         init_seed;

   always @(posedge CLOCK_50) begin
      if (init_go) begin
         for (int i = 0; i < 65536; i++) mem[i] <= init_byte(init_seed, i);
      end else begin
         if (mem_re) mem_rdata <= mem[mem_addr];
         if (mem_we) mem[mem_addr] <= mem_wdata;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] ref_read(input logic [15:0] a);
      logic [15:0] a1;
      a1 = a + 16'd1;
      return {ref_mem[a1], ref_mem[a]};
   endfunction

   task automatic load_mem(input int seed);
      @(negedge CLOCK_50);
      init_seed = seed;
      init_go   = 1'b1;
      for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(seed, i);
      @(negedge CLOCK_50);
      init_go = 1'b0;
   endtask

   typedef struct {
      logic        is_data;
      logic        rw;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_word;
      int          exp_lat;
      logic [15:0] exp_a0;
      logic [15:0] exp_a1;
   } vec_t;

   vec_t        vecs [9];
   logic [15:0] last_rd;

   task automatic run_vec(input int idx, input vec_t v);
      int          lat, nstr, stall_bad;
      logic [15:0] a [2];
      logic [7:0]  wd [2];
      logic [15:0] word;
      logic        dn, st;
      lat = -1; nstr = 0; stall_bad = 0; word = 16'h0;
      a[0] = 16'h0; a[1] = 16'h0; wd[0] = 8'h0; wd[1] = 8'h0;
      @(negedge CLOCK_50);
      if (v.is_data) begin
         data_req = 1'b1; data_rw = v.rw; data_addr = v.addr; data_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      for (int k = 0; k < 20 && lat < 0; k++) begin
         if (k > 0) @(negedge CLOCK_50);
         #2;
         if (mem_re || mem_we) begin
            if (nstr < 2) begin
               a[nstr] = mem_addr; wd[nstr] = mem_wdata;
            end
            nstr++;
         end
         dn = v.is_data ? data_done : if_done;
         st = v.is_data ? data_stall : if_stall;
         if (dn) begin
            lat  = k;
            word = v.is_data ? data_rdata : if_rdata;
            if (st) stall_bad++;
            if_req = 1'b0; data_req = 1'b0;
         end else if (!st) begin
            stall_bad++;
         end
      end
      chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
      chk($sformatf("v%0d_strobes", idx), 32'(nstr), 32'd2);
      chk($sformatf("v%0d_addr0", idx), {16'h0, a[0]}, {16'h0, v.exp_a0});
      chk($sformatf("v%0d_addr1", idx), {16'h0, a[1]}, {16'h0, v.exp_a1});
      chk($sformatf("v%0d_stall", idx), 32'(stall_bad), 32'd0);
      if (v.rw) begin
         chk($sformatf("v%0d_wbytes", idx), {16'h0, wd[1], wd[0]}, {16'h0, v.wdata});
         chk($sformatf("v%0d_rdata_held", idx), {16'h0, data_rdata}, {16'h0, last_rd});
      end else begin
         chk($sformatf("v%0d_rword", idx), {16'h0, word}, {16'h0, v.exp_word});
         if (v.is_data) last_rd = v.exp_word;
      end
   endtask

   function automatic logic [15:0] pick_addr();
      if ($urandom_range(0, 3) == 0) return 16'($urandom);
      return 16'hFFF8 + 16'($urandom_range(0, 15));
   endfunction

   task automatic rand_fetch(input int n, input int max_gap);
      for (int t = 0; t < n; t++) begin
         logic [15:0] a;
         int          lat;
         a = pick_addr();
         lat = -1;
         repeat ($urandom_range(0, max_gap)) @(negedge CLOCK_50);
         @(negedge CLOCK_50);
         #2;
         if_req = 1'b1; if_addr = a;
         for (int k = 0; k < 30 && lat < 0; k++) begin
            if (k > 0) begin @(negedge CLOCK_50); #2; end
            if (if_done) begin
               lat = k;
               chk("rand_if_rdata", {16'h0, if_rdata}, {16'h0, ref_read(a)});
               if_req = 1'b0;
            end
         end
         chk("rand_if_wait_bound", 32'(lat >= 4 && lat <= 9), 32'd1);
      end
   endtask

   task automatic rand_data(input int n, input int max_gap, input bit writes_only);
      for (int t = 0; t < n; t++) begin
         logic [15:0] a, wd, a1;
         logic        rw;
         int          lat;
         a = pick_addr(); a1 = a + 16'd1;
         wd = 16'($urandom);
         rw = writes_only ? 1'b1 : 1'($urandom_range(0, 1));
         lat = -1;
         repeat ($urandom_range(0, max_gap)) @(negedge CLOCK_50);
         @(negedge CLOCK_50);
         #2;
         data_req = 1'b1; data_rw = rw; data_addr = a; data_wdata = wd;
         for (int k = 0; k < 30 && lat < 0; k++) begin
            if (k > 0) begin @(negedge CLOCK_50); #2; end
            if (data_done) begin
               lat = k;
               if (rw) begin
                  ref_mem[a]  = wd[7:0];
                  ref_mem[a1] = wd[15:8];
               end else begin
                  chk("rand_data_rdata", {16'h0, data_rdata}, {16'h0, ref_read(a)});
               end
               data_req = 1'b0;
            end
         end
         chk("rand_data_wait_bound", 32'(lat >= 3 && lat <= 9), 32'd1);
      end
   endtask

   initial begin
      int          t_if, t_dt, t_f0if, t_f0dt, bad_done;
      logic [15:0] w_if, w_dt;

      reset = 1'b1; init_go = 1'b0; init_seed = 0;
      if_req = 1'b0; data_req = 1'b0; data_rw = 1'b0;
      if_addr = 16'h0; data_addr = 16'h0; data_wdata = 16'h0;
      f0_if_req = 1'b0; f0_data_req = 1'b0; f0_mem_rdata = 8'h00;

      load_mem(0);
      repeat (2) @(posedge CLOCK_50);
      @(negedge CLOCK_50); #2;
      chk("reset_ctl", {25'h0, busy, mem_re, mem_we, if_done, data_done, if_stall, data_stall}, 32'h0);
      chk("reset_addr", {16'h0, mem_addr}, 32'h0);
      chk("reset_rdata", {if_rdata, data_rdata}, 32'h0);

      // Both requesters rise together straight out of reset on both instances.
      @(negedge CLOCK_50);
      reset = 1'b0;
      if_addr = 16'h0010; data_addr = 16'h0011; data_rw = 1'b0;
      if_req = 1'b1; data_req = 1'b1; f0_if_req = 1'b1; f0_data_req = 1'b1;
      t_if = -1; t_dt = -1; t_f0if = -1; t_f0dt = -1; w_if = 16'h0; w_dt = 16'h0;
      for (int k = 0; k < 25; k++) begin
         if (k > 0) @(negedge CLOCK_50);
         #2;
         if (if_done && t_if < 0) begin t_if = k; w_if = if_rdata; if_req = 1'b0; end
         if (data_done && t_dt < 0) begin t_dt = k; w_dt = data_rdata; data_req = 1'b0; end
         if (f0_if_done && t_f0if < 0) begin t_f0if = k; f0_if_req = 1'b0; end
         if (f0_data_done && t_f0dt < 0) begin t_f0dt = k; f0_data_req = 1'b0; end
      end
      chk("fair_if_first", 32'(t_if), 32'd4);
      chk("fair_data_second", 32'(t_dt), 32'd9);
      chk("fixed_data_first", 32'(t_f0dt), 32'd4);
      chk("fixed_if_second", 32'(t_f0if), 32'd9);
      chk("contend_if_word", {16'h0, w_if}, 32'h1234);
      chk("contend_data_word", {16'h0, w_dt}, 32'h9A12);
      last_rd = 16'h9A12;

      vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h1234, 4, 16'h0010, 16'h0011};
      vecs[1] = '{1'b1, 1'b1, 16'h0020, 16'hBEEF, 16'h0000, 3, 16'h0020, 16'h0021};
      vecs[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'hBEEF, 4, 16'h0020, 16'h0021};
      vecs[3] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h55AA, 4, 16'hFFFF, 16'h0000};
      vecs[4] = '{1'b1, 1'b0, 16'h0011, 16'h0000, 16'h9A12, 4, 16'h0011, 16'h0012};
      vecs[5] = '{1'b1, 1'b1, 16'hFFFF, 16'hC0DE, 16'h0000, 3, 16'hFFFF, 16'h0000};
      vecs[6] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hC0DE, 4, 16'hFFFF, 16'h0000};
      vecs[7] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'hC0DE, 4, 16'hFFFF, 16'h0000};
      vecs[8] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'hBEEF, 4, 16'h0020, 16'h0021};
      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // Reset lands while the high byte of a write is on the bus.
      @(negedge CLOCK_50);
      data_req = 1'b1; data_rw = 1'b1; data_addr = 16'h0040; data_wdata = 16'h1234;
      @(negedge CLOCK_50); #2;
      chk("rst_wr0", {7'h0, mem_we, mem_addr, mem_wdata}, {7'h0, 1'b1, 16'h0040, 8'h34});
      @(negedge CLOCK_50); #2;
      chk("rst_wr1", {7'h0, mem_we, mem_addr, mem_wdata}, {7'h0, 1'b1, 16'h0041, 8'h12});
      reset = 1'b1; data_req = 1'b0;
      @(negedge CLOCK_50); #2;
      chk("rst_idle", {28'h0, busy, mem_we, mem_re, data_done}, 32'h0);
      chk("rst_rdata_cleared", {16'h0, data_rdata}, 32'h0);
      reset = 1'b0;
      bad_done = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLOCK_50); #2;
         if (data_done || if_done || busy) bad_done++;
      end
      chk("rst_no_done", 32'(bad_done), 32'd0);
      chk("rst_low_byte", {24'h0, mem[16'h0040]}, 32'h34);

      // Continuous fetch against back-to-back writes, then mixed random traffic.
      load_mem(7);
      fork
         rand_fetch(20, 0);
         rand_data(20, 0, 1'b1);
      join
      load_mem(23);
      fork
         rand_fetch(40, 3);
         rand_data(40, 3, 1'b0);
      join

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
